// File: rtl/cpu_exec_pkg.sv
// Shared execute-stage types: ALU opcodes, FSM states and the commit control bundle.
package cpu_exec_pkg;

    typedef enum logic [2:0] {
        AluAdd = 3'd0,
        AluSub = 3'd1,
        AluAnd = 3'd2,
        AluOr  = 3'd3,
        AluXor = 3'd4,
        AluSll = 3'd5,
        AluSrl = 3'd6,
        AluMul = 3'd7
    } alu_op_t;

    typedef enum logic {
        StIdle    = 1'b0,
        StMulBusy = 1'b1
    } exec_state_t;

    typedef struct packed {
        logic valid;
        logic mem_write;
        logic mem_read;
        logic mem_to_reg;
        logic reg_write;
    } commit_ctrl_t;

endpackage

// File: rtl/cpu_iter_mul.sv
// Multi-cycle multiplier: operands latched on start, done raised on the last count.
module cpu_iter_mul
    import cpu_exec_pkg::*;
#(
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic                 i_run,
    input  logic                 i_abort,
    input  logic [REG_WIDTH-1:0] i_a,
    input  logic [REG_WIDTH-1:0] i_b,
    output logic                 o_done,
    output logic [REG_WIDTH-1:0] o_product
);

    localparam int unsigned CNT_W = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);

    logic [CNT_W-1:0]     r_cnt;
    logic [REG_WIDTH-1:0] r_a;
    logic [REG_WIDTH-1:0] r_b;

    always_ff @(posedge clock) begin
        if (reset || i_abort || i_start) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (i_start) begin
            r_a <= i_a;
            r_b <= i_b;
        end
    end

    assign o_done    = (r_cnt == LAST);
    assign o_product = r_a * r_b;

endmodule

// File: rtl/cpu_execute_stage.sv
// Execute stage: operand forwarding, ALU/address generation and a multi-cycle MUL.
// Define CPU_EXEC_FORWARD_EN to include the commit/writeback forwarding muxes.
module cpu_execute_stage
    import cpu_exec_pkg::*;
#(
    parameter int unsigned REG_WIDTH          = 32,
    parameter int unsigned VIRTUAL_ADDR_WIDTH = 32,
    parameter int unsigned NUM_REGS           = 32,
    parameter int unsigned MUL_CYCLES         = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [2:0]                    in_alu_op,
    input  logic                          in_use_reg_b,
    input  logic                          in_mem_write,
    input  logic                          in_mem_read,
    input  logic                          in_mem_to_reg,
    input  logic                          in_reg_write,
    input  logic [VIRTUAL_ADDR_WIDTH-1:0] in_next_pc,
    input  logic [REG_WIDTH-1:0]          in_ra_data,
    input  logic [REG_WIDTH-1:0]          in_rb_data,
    input  logic [REG_WIDTH-1:0]          in_offset,
    input  logic [$clog2(NUM_REGS)-1:0]   in_ra_id,
    input  logic [$clog2(NUM_REGS)-1:0]   in_rb_id,
    input  logic [$clog2(NUM_REGS)-1:0]   in_reg_dest,
    input  logic                          cm_reg_write,
    input  logic [$clog2(NUM_REGS)-1:0]   cm_reg_dest,
    input  logic [REG_WIDTH-1:0]          cm_result,
    input  logic                          wb_reg_write,
    input  logic [$clog2(NUM_REGS)-1:0]   wb_reg_dest,
    input  logic [REG_WIDTH-1:0]          wb_data,
    input  logic                          stall_in,
    input  logic                          flush,
    output logic                          stall_out,
    output logic                          out_valid,
    output logic [REG_WIDTH-1:0]          out_result,
    output logic [REG_WIDTH-1:0]          out_store_data,
    output logic                          out_mem_write,
    output logic                          out_mem_read,
    output logic                          out_mem_to_reg,
    output logic                          out_reg_write,
    output logic [$clog2(NUM_REGS)-1:0]   out_reg_dest,
    output logic [VIRTUAL_ADDR_WIDTH-1:0] out_next_pc
);

    localparam int unsigned ID_W = $clog2(NUM_REGS);
    localparam int unsigned SH_W = $clog2(REG_WIDTH);

    logic [REG_WIDTH-1:0] w_ra, w_rb, w_op_b, w_alu, w_product;
    logic [SH_W-1:0]      w_shamt;
    alu_op_t              w_op;

`ifdef CPU_EXEC_FORWARD_EN
    // Commit is younger than writeback, so it wins when both target the same register.
    always_comb begin
        w_ra = in_ra_data;
        if (cm_reg_write && cm_reg_dest == in_ra_id)      w_ra = cm_result;
        else if (wb_reg_write && wb_reg_dest == in_ra_id) w_ra = wb_data;
        w_rb = in_rb_data;
        if (cm_reg_write && cm_reg_dest == in_rb_id)      w_rb = cm_result;
        else if (wb_reg_write && wb_reg_dest == in_rb_id) w_rb = wb_data;
    end
`else
    assign w_ra = in_ra_data;
    assign w_rb = in_rb_data;
    logic w_unused_fwd;
    assign w_unused_fwd = ^{cm_reg_write, cm_reg_dest, cm_result, wb_reg_write, wb_reg_dest,
                            wb_data, in_ra_id, in_rb_id};
`endif

    assign w_op    = alu_op_t'(in_alu_op);
    assign w_op_b  = in_use_reg_b ? w_rb : in_offset;
    assign w_shamt = w_op_b[SH_W-1:0];

    always_comb begin
        w_alu = '0;
        if (in_mem_read || in_mem_write) begin
            w_alu = w_ra + in_offset;
        end else begin
            case (w_op)
                AluAdd:  w_alu = w_ra + w_op_b;
                AluSub:  w_alu = w_ra - w_op_b;
                AluAnd:  w_alu = w_ra & w_op_b;
                AluOr:   w_alu = w_ra | w_op_b;
                AluXor:  w_alu = w_ra ^ w_op_b;
                AluSll:  w_alu = w_ra << w_shamt;
                AluSrl:  w_alu = w_ra >> w_shamt;
                default: w_alu = '0;
            endcase
        end
    end

    exec_state_t r_state, w_state_next;
    logic        w_is_mul, w_mul_start, w_mul_run, w_mul_done;

    assign w_is_mul = in_valid && (w_op == AluMul);

    always_ff @(posedge clock) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = StIdle;
        end else if (!stall_in) begin
            case (r_state)
                StIdle:    if (w_is_mul) w_state_next = StMulBusy;
                StMulBusy: if (w_mul_done) w_state_next = StIdle;
                default:   w_state_next = StIdle;
            endcase
        end
    end

    always_comb begin
        w_mul_start = (r_state == StIdle) && w_is_mul && !flush && !stall_in;
        w_mul_run   = (r_state == StMulBusy) && !flush && !stall_in;
        stall_out   = ((r_state == StIdle) && w_is_mul && !flush)
                   || ((r_state == StMulBusy) && !w_mul_done) || stall_in;
    end

    cpu_iter_mul #(
        .REG_WIDTH  (REG_WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clock     (clock),
        .reset     (reset),
        .i_start   (w_mul_start),
        .i_run     (w_mul_run),
        .i_abort   (flush),
        .i_a       (w_ra),
        .i_b       (w_op_b),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    commit_ctrl_t                  w_in_ctrl, r_mul_ctrl, r_ctrl, w_ctrl_next;
    logic [REG_WIDTH-1:0]          r_mul_store, r_result, w_result_next, r_store, w_store_next;
    logic [ID_W-1:0]               r_mul_dest, r_dest, w_dest_next;
    logic [VIRTUAL_ADDR_WIDTH-1:0] r_mul_pc, r_pc, w_pc_next;

    assign w_in_ctrl = '{valid: 1'b1, mem_write: in_mem_write, mem_read: in_mem_read,
                         mem_to_reg: in_mem_to_reg, reg_write: in_reg_write};

    // Control of an in-flight multiply is captured at accept time and replayed on completion.
    always_ff @(posedge clock) begin
        if (w_mul_start) begin
            r_mul_ctrl  <= w_in_ctrl;
            r_mul_store <= w_rb;
            r_mul_dest  <= in_reg_dest;
            r_mul_pc    <= in_next_pc;
        end
    end

    always_comb begin
        w_ctrl_next   = '0;
        w_result_next = '0;
        w_store_next  = '0;
        w_dest_next   = '0;
        w_pc_next     = '0;
        if (r_state == StMulBusy) begin
            if (w_mul_done) begin
                w_ctrl_next   = r_mul_ctrl;
                w_result_next = w_product;
                w_store_next  = r_mul_store;
                w_dest_next   = r_mul_dest;
                w_pc_next     = r_mul_pc;
            end
        end else if (in_valid && !w_is_mul) begin
            w_ctrl_next   = w_in_ctrl;
            w_result_next = w_alu;
            w_store_next  = w_rb;
            w_dest_next   = in_reg_dest;
            w_pc_next     = in_next_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_ctrl   <= '0;
            r_result <= '0;
            r_store  <= '0;
            r_dest   <= '0;
            r_pc     <= '0;
        end else if (!stall_in) begin
            r_ctrl   <= w_ctrl_next;
            r_result <= w_result_next;
            r_store  <= w_store_next;
            r_dest   <= w_dest_next;
            r_pc     <= w_pc_next;
        end
    end

    assign out_valid      = r_ctrl.valid;
    assign out_mem_write  = r_ctrl.mem_write;
    assign out_mem_read   = r_ctrl.mem_read;
    assign out_mem_to_reg = r_ctrl.mem_to_reg;
    assign out_reg_write  = r_ctrl.reg_write;
    assign out_result     = r_result;
    assign out_store_data = r_store;
    assign out_reg_dest   = r_dest;
    assign out_next_pc    = r_pc;

endmodule

// File: tb/tb_cpu_execute_stage.sv
// Self-checking bench for cpu_execute_stage: transaction-level model plus directed vectors.
module tb_cpu_execute_stage;

    localparam int unsigned RW = 32;
    localparam int unsigned MC = 4;
`ifdef CPU_EXEC_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, in_valid, in_use_reg_b, in_mem_write, in_mem_read, in_mem_to_reg;
    logic        in_reg_write, cm_reg_write, wb_reg_write, stall_in, flush;
    logic [2:0]  in_alu_op;
    logic [31:0] in_next_pc, in_ra_data, in_rb_data, in_offset, cm_result, wb_data;
    logic [4:0]  in_ra_id, in_rb_id, in_reg_dest, cm_reg_dest, wb_reg_dest;
    logic        stall_out, out_valid, out_mem_write, out_mem_read, out_mem_to_reg, out_reg_write;
    logic [31:0] out_result, out_store_data, out_next_pc;
    logic [4:0]  out_reg_dest;

    always #5 clock = ~clock;

    cpu_execute_stage #(
        .REG_WIDTH(RW), .VIRTUAL_ADDR_WIDTH(32), .NUM_REGS(32), .MUL_CYCLES(MC)
    ) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_alu_op(in_alu_op),
        .in_use_reg_b(in_use_reg_b), .in_mem_write(in_mem_write), .in_mem_read(in_mem_read),
        .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write), .in_next_pc(in_next_pc),
        .in_ra_data(in_ra_data), .in_rb_data(in_rb_data), .in_offset(in_offset),
        .in_ra_id(in_ra_id), .in_rb_id(in_rb_id), .in_reg_dest(in_reg_dest),
        .cm_reg_write(cm_reg_write), .cm_reg_dest(cm_reg_dest), .cm_result(cm_result),
        .wb_reg_write(wb_reg_write), .wb_reg_dest(wb_reg_dest), .wb_data(wb_data),
        .stall_in(stall_in), .flush(flush), .stall_out(stall_out), .out_valid(out_valid),
        .out_result(out_result), .out_store_data(out_store_data),
        .out_mem_write(out_mem_write), .out_mem_read(out_mem_read),
        .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write),
        .out_reg_dest(out_reg_dest), .out_next_pc(out_next_pc)
    );

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        valid, mw, mr, m2r, rw;
        logic [4:0]  dest;
        logic [31:0] pc, result, store;
    } exp_t;

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] p;
        int          sh;
        p  = {32'b0, a} * {32'b0, b};
        sh = int'(b % 32);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << sh;
            3'd6:    return a >> sh;
            default: return p[31:0];
        endcase
    endfunction

    logic [31:0] m_fa, m_fb, m_opb, m_res;
    exp_t        m_now;
    exp_t        e = '0;
    exp_t        m_hold = '0;
    bit          m_busy = 1'b0;
    int          m_left = 0;
    logic        exp_stall;

    assign m_fa = (FWD_EN && cm_reg_write && cm_reg_dest == in_ra_id) ? cm_result :
                  (FWD_EN && wb_reg_write && wb_reg_dest == in_ra_id) ? wb_data : in_ra_data;
    assign m_fb = (FWD_EN && cm_reg_write && cm_reg_dest == in_rb_id) ? cm_result :
                  (FWD_EN && wb_reg_write && wb_reg_dest == in_rb_id) ? wb_data : in_rb_data;
    assign m_opb = in_use_reg_b ? m_fb : in_offset;
    assign m_res = (in_mem_read || in_mem_write) ? m_fa + in_offset
                                                 : alu_ref(in_alu_op, m_fa, m_opb);
    assign m_now = '{valid: 1'b1, mw: in_mem_write, mr: in_mem_read, m2r: in_mem_to_reg,
                     rw: in_reg_write, dest: in_reg_dest, pc: in_next_pc, result: m_res,
                     store: m_fb};
    // m_left counts edges still to go before a multiply's result is visible.
    assign exp_stall = stall_in || (m_busy && m_left > 1)
                    || (!m_busy && in_valid && in_alu_op == 3'd7 && !flush);

    always @(posedge clock) begin
        if (reset || flush) begin
            e      <= '0;
            m_busy <= 1'b0;
        end else if (!stall_in) begin
            if (m_busy) begin
                if (m_left == 1) begin
                    e      <= m_hold;
                    m_busy <= 1'b0;
                end else begin
                    e      <= '0;
                    m_left <= m_left - 1;
                end
            end else if (in_valid && in_alu_op == 3'd7) begin
                e      <= '0;
                m_busy <= 1'b1;
                m_left <= MC;
                m_hold <= m_now;
            end else if (in_valid) begin
                e <= m_now;
            end else begin
                e <= '0;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("valid", 32'(out_valid), 32'(e.valid));
            check("mem_write", 32'(out_mem_write), 32'(e.mw));
            check("mem_read", 32'(out_mem_read), 32'(e.mr));
            check("mem_to_reg", 32'(out_mem_to_reg), 32'(e.m2r));
            check("reg_write", 32'(out_reg_write), 32'(e.rw));
            check("stall_out", 32'(stall_out), 32'(exp_stall));
            if (e.valid) begin
                check("result", out_result, e.result);
                check("store_data", out_store_data, e.store);
                check("reg_dest", 32'(out_reg_dest), 32'(e.dest));
                check("next_pc", out_next_pc, e.pc);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_bus();
        in_valid = 0; in_alu_op = 0; in_use_reg_b = 0; in_mem_write = 0; in_mem_read = 0;
        in_mem_to_reg = 0; in_reg_write = 0; in_ra_data = 0; in_rb_data = 0; in_offset = 0;
        in_ra_id = 5'd1; in_rb_id = 5'd2; in_reg_dest = 0; in_next_pc = 0;
    endtask

    task automatic drive(input logic [2:0] op, input logic use_b, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] off, input logic mr,
                         input logic mw, input logic [4:0] dest, input logic [31:0] pc);
        in_valid = 1; in_alu_op = op; in_use_reg_b = use_b; in_ra_data = a; in_rb_data = b;
        in_offset = off; in_mem_read = mr; in_mem_write = mw; in_mem_to_reg = mr;
        in_reg_write = !mw; in_reg_dest = dest; in_next_pc = pc;
    endtask

    logic [2:0]  t_op[6]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [31:0] t_a[6]   = '{32'd10, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'd1, 32'h8000_0000};
    logic [31:0] t_b[6]   = '{32'd3, 32'hFF00, 32'hFF00, 32'hFF00, 32'd33, 32'd31};
    logic [31:0] t_exp[6] = '{32'd7, 32'hF000, 32'hFFF0, 32'h0FF0, 32'd2, 32'd1};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        int edges;
        reset = 1; stall_in = 0; flush = 0;
        cm_reg_write = 0; cm_reg_dest = 0; cm_result = 0;
        wb_reg_write = 0; wb_reg_dest = 0; wb_data = 0;
        idle_bus();
        tick();
        chk_en = 1;
        tick();
        reset = 0;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_result", out_result, 32'd0);
        check("reset_stall", 32'(stall_out), 32'd0);

        // ADD with immediate
        drive(3'd0, 1'b0, 32'd5, 32'd0, 32'd7, 1'b0, 1'b0, 5'd9, 32'h100);
        tick();
        idle_bus();
        check("add_result", out_result, 32'd12);
        check("add_valid", 32'(out_valid), 32'd1);

        // Forwarding: commit beats writeback, then writeback alone
        drive(3'd0, 1'b0, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 5'd4, 32'h104);
        in_ra_id = 5'd3;
        cm_reg_write = 1; cm_reg_dest = 5'd3; cm_result = 32'd100;
        wb_reg_write = 1; wb_reg_dest = 5'd3; wb_data = 32'd50;
        tick();
        check("fwd_commit_wins", out_result, FWD_EN ? 32'd100 : 32'd1);
        cm_reg_dest = 5'd8;
        tick();
        check("fwd_writeback", out_result, FWD_EN ? 32'd50 : 32'd1);
        cm_reg_write = 0; wb_reg_write = 0;
        idle_bus();

        // Back-to-back register ops, one per cycle
        for (int i = 0; i < 6; i++) begin
            drive(t_op[i], 1'b1, t_a[i], t_b[i], 32'd0, 1'b0, 1'b0, 5'(i + 10), 32'h200 + i);
            tick();
            check("op_table", out_result, t_exp[i]);
        end

        // Memory address generation ignores the ALU op; store data is rb
        drive(3'd2, 1'b1, 32'h1000, 32'h55, 32'h24, 1'b1, 1'b0, 5'd6, 32'h300);
        tick();
        check("load_addr", out_result, 32'h1024);
        drive(3'd4, 1'b1, 32'h2000, 32'hABCD, 32'h8, 1'b0, 1'b1, 5'd0, 32'h304);
        tick();
        check("store_addr", out_result, 32'h2008);
        check("store_data_lit", out_store_data, 32'hABCD);
        idle_bus();
        tick();

        // MUL: decode holds the bundle while stall_out is high
        drive(3'd7, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 1'b0, 5'd7, 32'h400);
        stalls = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!stall_out) break;
            stalls++;
            tick();
        end
        check("mul_stall_cycles", 32'(stalls), 32'd4);
        tick();
        idle_bus();
        check("mul_result", out_result, 32'hFFFF_FFFE);
        check("mul_valid", 32'(out_valid), 32'd1);
        tick();

        // Flush at cnt=1 of a MUL
        drive(3'd7, 1'b1, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 5'd5, 32'h500);
        tick();
        tick();
        flush = 1;
        tick();
        flush = 0;
        idle_bus();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_stall", 32'(stall_out), 32'd0);
        repeat (MC) tick();
        check("flush_no_result", 32'(out_valid), 32'd0);
        drive(3'd0, 1'b0, 32'd2, 32'd0, 32'd3, 1'b0, 1'b0, 5'd1, 32'h504);
        tick();
        idle_bus();
        check("post_flush_add", out_result, 32'd5);
        check("post_flush_valid", 32'(out_valid), 32'd1);

        // stall_in holds SUB 3-5 and does not consume the next bundle
        drive(3'd1, 1'b1, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 5'd2, 32'h600);
        tick();
        check("sub_result", out_result, 32'hFFFF_FFFE);
        drive(3'd0, 1'b0, 32'd1, 32'd0, 32'd1, 1'b0, 1'b0, 5'd3, 32'h604);
        stall_in = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_hold", out_result, 32'hFFFF_FFFE);
        end
        stall_in = 0;
        tick();
        idle_bus();
        check("after_stall", out_result, 32'd2);
        tick();
        check("after_stall_bubble", 32'(out_valid), 32'd0);

        // stall_in in the middle of a MUL stretches it by the stall length
        drive(3'd7, 1'b1, 32'd6, 32'd7, 32'd0, 1'b0, 1'b0, 5'd4, 32'h700);
        tick();
        tick();
        stall_in = 1;
        tick();
        tick();
        stall_in = 0;
        edges = 4;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) break;
            tick();
            edges++;
        end
        idle_bus();
        check("mul_stall_edges", 32'(edges), 32'(MC + 3));
        check("mul_stall_result", out_result, 32'd42);

        // flush beats stall_in
        drive(3'd0, 1'b0, 32'd1, 32'd0, 32'd1, 1'b0, 1'b0, 5'd1, 32'h800);
        tick();
        idle_bus();
        stall_in = 1; flush = 1;
        tick();
        stall_in = 0; flush = 0;
        check("flush_over_stall", 32'(out_valid), 32'd0);

        // Reset during MUL_BUSY aborts it
        drive(3'd7, 1'b1, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 5'd3, 32'h900);
        tick();
        tick();
        reset = 1;
        idle_bus();
        tick();
        reset = 0;
        check("rst_mul_valid", 32'(out_valid), 32'd0);
        check("rst_mul_result", out_result, 32'd0);
        check("rst_mul_stall", 32'(stall_out), 32'd0);
        repeat (MC) tick();
        check("rst_mul_no_result", 32'(out_valid), 32'd0);
        drive(3'd0, 1'b0, 32'd4, 32'd0, 32'd4, 1'b0, 1'b0, 5'd2, 32'h904);
        tick();
        idle_bus();
        check("rst_then_add", out_result, 32'd8);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
